// File: rtl/switch_pkg.sv
// Constants and write-FSM state encoding shared by the switch ingress blocks.
package switch_pkg;

    localparam int N_PORTS    = 4;
    localparam int IDX_WIDTH  = 2;
    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_BODY = 2'd1,
        WR_DROP = 2'd2
    } wr_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; push is refused while full.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full
);
    import switch_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && (r_count != {(AW+1){1'b0}});
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array, no reset needed: contents are qualified by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end else begin
            r_mem[r_wr_ptr] <= r_mem[r_wr_ptr];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ingress_buffer.sv
// Store-and-forward ingress frame buffer: a frame is offered downstream only once fully written.
// Define INGRESS_DROP_EN to drop overflowing frames instead of back-pressuring upstream.
module ingress_buffer #(
    parameter int N_PORTS    = switch_pkg::N_PORTS,
    parameter int IDX_WIDTH  = $clog2(N_PORTS),
    parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
    parameter int DEPTH      = 64,
    parameter int DESC_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [IDX_WIDTH-1:0]          in_dst,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    output logic                          out_last,
    output logic [IDX_WIDTH-1:0]          out_dst,
    input  logic                          out_ready,
    output logic [$clog2(DESC_DEPTH):0]   frame_count,
    output logic [15:0]                   drop_count
);
    import switch_pkg::*;

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH:0]   r_mem [DEPTH];
    logic [PTR_WIDTH:0]    r_wr_ptr;
    logic [PTR_WIDTH:0]    r_rd_ptr;
    logic [IDX_WIDTH-1:0]  r_dst;
    wr_state_t             r_state;
    wr_state_t             w_state_nxt;

    logic [PTR_WIDTH:0]    w_data_used;
    logic                  w_data_full;
    logic                  w_desc_full;
    logic                  w_in_ready;
    logic                  w_wr_en;
    logic                  w_commit;
    logic [IDX_WIDTH-1:0]  w_commit_dst;
    logic                  w_pop;
    logic [DATA_WIDTH:0]   w_head;

`ifdef INGRESS_DROP_EN
    logic [PTR_WIDTH:0]    r_cm_ptr;
    logic [15:0]           r_drop_cnt;
    logic                  w_drop_start;
`endif

    assign w_data_used = r_wr_ptr - r_rd_ptr;
    assign w_data_full = (w_data_used == (PTR_WIDTH+1)'(DEPTH));
    assign in_ready    = w_in_ready && !reset;

    assign w_head      = r_mem[r_rd_ptr[PTR_WIDTH-1:0]];
    assign out_data    = w_head[DATA_WIDTH-1:0];
    assign out_last    = w_head[DATA_WIDTH];
    assign out_valid   = (frame_count != {($clog2(DESC_DEPTH)+1){1'b0}});
    assign w_pop       = out_valid && out_ready;

`ifdef INGRESS_DROP_EN
    assign drop_count  = r_drop_cnt;
`else
    assign drop_count  = 16'd0;
`endif

    sync_fifo #(
        .WIDTH (IDX_WIDTH),
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_commit),
        .i_data  (w_commit_dst),
        .i_pop   (w_pop && out_last),
        .o_data  (out_dst),
        .o_count (frame_count),
        .o_full  (w_desc_full)
    );

    // Write FSM: next state, upstream ready, beat write and frame commit strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_in_ready   = 1'b0;
        w_wr_en      = 1'b0;
        w_commit     = 1'b0;
        w_commit_dst = r_dst;
`ifdef INGRESS_DROP_EN
        w_drop_start = 1'b0;
`endif
        case (r_state)
            WR_IDLE: begin
                w_in_ready   = !w_data_full && !w_desc_full;
                w_commit_dst = in_dst;
                if (in_valid && w_in_ready) begin
                    w_wr_en = 1'b1;
                    if (in_last) begin
                        w_commit = 1'b1;
                    end else begin
                        w_state_nxt = WR_BODY;
                    end
                end else begin
                    w_state_nxt = WR_IDLE;
                end
`ifdef INGRESS_DROP_EN
                if (w_desc_full) begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_drop_start = 1'b1;
                        if (in_last) begin
                            w_state_nxt = WR_IDLE;
                        end else begin
                            w_state_nxt = WR_DROP;
                        end
                    end else begin
                        w_state_nxt = WR_IDLE;
                    end
                end else begin
                    w_drop_start = 1'b0;
                end
`endif
            end
            WR_BODY: begin
                w_in_ready = !w_data_full;
                if (in_valid && w_in_ready) begin
                    w_wr_en = 1'b1;
                    if (in_last) begin
                        w_commit    = 1'b1;
                        w_state_nxt = WR_IDLE;
                    end else begin
                        w_state_nxt = WR_BODY;
                    end
                end else begin
                    w_state_nxt = WR_BODY;
                end
`ifdef INGRESS_DROP_EN
                // Overflow mid-frame: rewind over the partial frame and swallow the rest.
                if (w_data_full) begin
                    w_in_ready = 1'b1;
                    if (in_valid) begin
                        w_drop_start = 1'b1;
                        if (in_last) begin
                            w_state_nxt = WR_IDLE;
                        end else begin
                            w_state_nxt = WR_DROP;
                        end
                    end else begin
                        w_state_nxt = WR_BODY;
                    end
                end else begin
                    w_drop_start = 1'b0;
                end
`endif
            end
`ifdef INGRESS_DROP_EN
            WR_DROP: begin
                w_in_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = WR_IDLE;
                end else begin
                    w_state_nxt = WR_DROP;
                end
            end
`endif
            default: begin
                w_state_nxt = WR_IDLE;
                w_in_ready  = 1'b0;
            end
        endcase
    end

    // Data store write port; words are qualified by the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= {in_last, in_data};
        end else begin
            r_mem[r_wr_ptr[PTR_WIDTH-1:0]] <= r_mem[r_wr_ptr[PTR_WIDTH-1:0]];
        end
    end

    // FSM state, pointers, latched destination and drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= WR_IDLE;
            r_wr_ptr <= {(PTR_WIDTH+1){1'b0}};
            r_rd_ptr <= {(PTR_WIDTH+1){1'b0}};
            r_dst    <= {IDX_WIDTH{1'b0}};
`ifdef INGRESS_DROP_EN
            r_cm_ptr   <= {(PTR_WIDTH+1){1'b0}};
            r_drop_cnt <= 16'd0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            if ((r_state == WR_IDLE) && w_wr_en) begin
                r_dst <= in_dst;
            end else begin
                r_dst <= r_dst;
            end
`ifdef INGRESS_DROP_EN
            if (w_commit) begin
                r_cm_ptr <= r_wr_ptr + 1'b1;
            end else begin
                r_cm_ptr <= r_cm_ptr;
            end
            if (w_drop_start) begin
                r_wr_ptr   <= r_cm_ptr;
                r_drop_cnt <= sat_inc16(r_drop_cnt);
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ingress_buffer.sv
// Directed self-checking bench for ingress_buffer (default parameters).
module tb_ingress_buffer;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic [1:0]  in_dst;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_last;
    logic [1:0]  out_dst;
    logic        out_ready;
    logic [3:0]  frame_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    ingress_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_dst      (in_dst),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_dst     (out_dst),
        .out_ready   (out_ready),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic l, input logic [1:0] dst);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_dst   = dst;
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input logic [1:0] dst);
        for (int i = 0; i < len; i++) begin
            int guard;
            guard = 0;
            drive(base + 8'(i), (i == len - 1), dst);
            while (!in_ready && guard < 200) begin
                tick();
                guard++;
            end
            check_value("send_ready", {31'd0, in_ready}, 32'd1);
            tick();
        end
        idle_in();
    endtask

    task automatic recv_beat(input string tag, input logic [7:0] d, input logic l, input logic [1:0] dst);
        int guard;
        guard = 0;
        out_ready = 1'b1;
        while (!out_valid && guard < 200) begin
            tick();
            guard++;
        end
        check_value({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_value({tag, "_data"},  {24'd0, out_data},  {24'd0, d});
        check_value({tag, "_last"},  {31'd0, out_last},  {31'd0, l});
        check_value({tag, "_dst"},   {30'd0, out_dst},   {30'd0, dst});
        tick();
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        out_ready = 1'b0;
        idle_in();
        tick();
        tick();
        check_value("rst_in_ready",    {31'd0, in_ready},    32'd0);
        check_value("rst_out_valid",   {31'd0, out_valid},   32'd0);
        check_value("rst_frame_count", {28'd0, frame_count}, 32'd0);
        check_value("rst_drop_count",  {16'd0, drop_count},  32'd0);
        reset = 1'b0;
        #1;
        check_value("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int idx;
        int cyc;
        reset     = 1'b1;
        in_dst    = 2'd0;
        out_ready = 1'b0;
        idle_in();
        apply_reset();

        // 4-beat frame, dst 2: visible only the cycle after its last beat
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'h11 * 8'(i + 1), (i == 3), 2'd2);
            check_value("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        idle_in();
        check_value("t1_valid_rise", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            recv_beat("t1_beat", 8'h11 * 8'(i + 1), (i == 3), 2'd2);
        end
        check_value("t1_empty_valid", {31'd0, out_valid},   32'd0);
        check_value("t1_empty_count", {28'd0, frame_count}, 32'd0);

        // three single-beat frames held, then released in order
        out_ready = 1'b0;
        send_frame(1, 8'hA0, 2'd0);
        send_frame(1, 8'hA1, 2'd1);
        send_frame(1, 8'hA3, 2'd3);
        check_value("t2_count3", {28'd0, frame_count}, 32'd3);
        recv_beat("t2_f0", 8'hA0, 1'b1, 2'd0);
        recv_beat("t2_f1", 8'hA1, 1'b1, 2'd1);
        recv_beat("t2_f3", 8'hA3, 1'b1, 2'd3);
        check_value("t2_count0", {28'd0, frame_count}, 32'd0);

        // out_ready toggling during a 6-beat frame: no valid bubbles
        out_ready = 1'b0;
        send_frame(6, 8'h60, 2'd1);
        idx = 0;
        cyc = 0;
        while (idx < 6 && cyc < 20) begin
            out_ready = (cyc % 2 == 0);
            check_value("t3_valid_held", {31'd0, out_valid}, 32'd1);
            check_value("t3_data", {24'd0, out_data}, 32'h60 + 32'(idx));
            check_value("t3_last", {31'd0, out_last}, {31'd0, (idx == 5)});
            tick();
            if (out_ready) idx++;
            cyc++;
        end
        out_ready = 1'b0;
        check_value("t3_beats_done", 32'(idx), 32'd6);
        check_value("t3_count0", {28'd0, frame_count}, 32'd0);

        // descriptor FIFO full with 8 frames
        for (int i = 0; i < 8; i++) begin
            send_frame(1, 8'h80 + 8'(i), 2'(i));
        end
        check_value("t4_count8", {28'd0, frame_count}, 32'd8);
`ifdef INGRESS_DROP_EN
        send_frame(1, 8'hEE, 2'd0);
        check_value("t4_drop1",       {16'd0, drop_count},  32'd1);
        check_value("t4_count_still", {28'd0, frame_count}, 32'd8);
`else
        check_value("t4_in_ready_low", {31'd0, in_ready},   32'd0);
        check_value("t4_no_drop",      {16'd0, drop_count}, 32'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            recv_beat("t4_drain", 8'h80 + 8'(i), 1'b1, 2'(i));
        end
        check_value("t4_count0", {28'd0, frame_count}, 32'd0);

`ifdef INGRESS_DROP_EN
        // oversize 70-beat frame dropped, stored frame and next frame intact
        apply_reset();
        send_frame(4, 8'h40, 2'd3);
        send_frame(70, 8'h00, 2'd1);
        check_value("t5_drop1",   {16'd0, drop_count},  32'd1);
        check_value("t5_count1",  {28'd0, frame_count}, 32'd1);
        check_value("t5_ready",   {31'd0, in_ready},    32'd1);
        send_frame(2, 8'hB0, 2'd2);
        check_value("t5_count2",  {28'd0, frame_count}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            recv_beat("t5_prior", 8'h40 + 8'(i), (i == 3), 2'd3);
        end
        recv_beat("t5_next0", 8'hB0, 1'b0, 2'd2);
        recv_beat("t5_next1", 8'hB1, 1'b1, 2'd2);
        check_value("t5_count0",  {28'd0, frame_count}, 32'd0);
`else
        // 64-beat frame fills the data store exactly (pointers wrap)
        out_ready = 1'b0;
        send_frame(64, 8'h00, 2'd1);
        check_value("t5_count1",     {28'd0, frame_count}, 32'd1);
        check_value("t5_full_ready", {31'd0, in_ready},    32'd0);
        out_ready = 1'b1;
        check_value("t5_pop_no_bypass", {31'd0, in_ready}, 32'd0);
        check_value("t5_first_data",    {24'd0, out_data}, 32'h00);
        tick();
        check_value("t5_ready_after_pop", {31'd0, in_ready}, 32'd1);
        for (int i = 1; i < 64; i++) begin
            recv_beat("t5_drain", 8'(i), (i == 63), 2'd1);
        end
        check_value("t5_count0", {28'd0, frame_count}, 32'd0);
`endif

        // reset on beat 3 of a 5-beat frame
        out_ready = 1'b0;
        drive(8'h50, 1'b0, 2'd3);
        tick();
        drive(8'h51, 1'b0, 2'd3);
        tick();
        drive(8'h52, 1'b0, 2'd3);
        reset = 1'b1;
        #1;
        check_value("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        tick();
        idle_in();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_value("t6_no_partial",  {31'd0, out_valid},   32'd0);
            check_value("t6_frame_count", {28'd0, frame_count}, 32'd0);
            tick();
        end
        send_frame(3, 8'hC0, 2'd2);
        for (int i = 0; i < 3; i++) begin
            recv_beat("t6_next", 8'hC0 + 8'(i), (i == 2), 2'd2);
        end
        check_value("t6_count0", {28'd0, frame_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ingress_buffer.md
INGRESS_BUFFER -- requirements
Module: ingress_buffer

Interface
REQ-001 Parameter N_PORTS, default 4, number of switch ports.
REQ-002 Parameter IDX_WIDTH, default 2, log2(N_PORTS), port index width.
REQ-003 Parameter DATA_WIDTH, default 8, payload beat width.
REQ-004 Parameter DEPTH, default 64, data-store words (power of 2); PTR_WIDTH = log2(DEPTH).
REQ-005 Parameter DESC_DEPTH, default 8, max stored complete frames (power of 2).
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 in_data  input  DATA_WIDTH  upstream beat payload.
REQ-009 in_valid / in_last  input  1 each  upstream beat valid / final beat of frame.
REQ-010 in_dst  input  IDX_WIDTH  destination egress port, sampled on first beat only.
REQ-011 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-012 out_data  output  DATA_WIDTH  head-frame beat to crossbar.
REQ-013 out_valid / out_last  output  1 each  to per-egress schedulers' ingress_valid/ingress_last bit.
REQ-014 out_dst  output  IDX_WIDTH  head-frame destination, to schedulers' ingress_dst.
REQ-015 out_ready  input  1  OR of all schedulers' ingress_ready bit for this port.
REQ-016 frame_count  output  log2(DESC_DEPTH)+1  complete frames stored.
REQ-017 drop_count  output  16  saturating count of dropped frames.

Function
REQ-018 Store-and-forward: a frame is visible at output only after its last beat is written; out_valid rises the cycle after last-beat acceptance.
REQ-019 Data store holds {last, data} per word; descriptor FIFO holds dst per complete frame.
REQ-020 Write FSM states WR_IDLE (awaiting first beat), WR_BODY (mid-frame), WR_DROP (discard, macro only).
REQ-021 WR_IDLE: in_ready = data not full && descriptor not full; first accepted beat latches in_dst, writes word, -> WR_BODY unless in_last (single-beat frame: commit, stay WR_IDLE).
REQ-022 WR_BODY: in_ready = data not full; accepted in_last beat commits frame (commit pointer := write pointer+1, push dst) -> WR_IDLE.
REQ-023 Uncommitted words occupy space but never appear at output.
REQ-024 out_valid = (frame_count != 0); out_data/out_last = word at read pointer; out_dst = descriptor head; combinational from stored state.
REQ-025 Pop on out_valid && out_ready: read pointer +1 (mod DEPTH); if out_last also pop descriptor.
REQ-026 out_valid held continuously from first to last beat of a frame (no bubbles), satisfying scheduler's valid-drop-abort rule.
REQ-027 Pointers wrap modulo DEPTH / DESC_DEPTH; full/empty from PTR_WIDTH+1-bit occupancy counts.
REQ-028 Full evaluated on registered occupancy; a pop in the same cycle does not bypass full (in_ready stays low that cycle).
REQ-029 Simultaneous commit and last-beat pop: frame_count unchanged.
REQ-030 Without drop feature, frames longer than DEPTH words are an upstream protocol violation (unsupported).

Reset
REQ-031 On reset: pointers, counts, frame_count, drop_count = 0; write FSM = WR_IDLE; out_valid = 0; in_ready = 0 while reset asserted.
REQ-032 Reset mid-frame discards all stored and partial frames; no partial frame surfaces after reset.

Configuration
REQ-033 Macro INGRESS_DROP_EN: when defined, overflow drops instead of backpressure.
REQ-034 With INGRESS_DROP_EN: WR_IDLE with descriptor full, or WR_BODY with data full and in_valid -> WR_DROP; write pointer := commit pointer; in_ready = 1; beats discarded through in_last -> WR_IDLE; drop_count +1 (saturate at 0xFFFF).
REQ-035 Without INGRESS_DROP_EN: WR_DROP absent, in_ready deasserts on full, drop_count tied 0.

Structure
REQ-036 Shared package switch_pkg: N_PORTS, IDX_WIDTH, DATA_WIDTH constants and write-FSM state typedef.
REQ-037 One sub-module sync_fifo instantiated for the descriptor FIFO; data store and commit logic inline.

Verification
REQ-038 4-beat frame dst=2, out_ready=1 -> out_valid rises 1 cycle after last beat; 4 beats out, out_dst=2, out_last on beat 4.
REQ-039 Three single-beat frames dst 0,1,3, out_ready=0 -> frame_count=3; then release -> order 0,1,3, frame_count 0.
REQ-040 out_ready toggled 1/0 during 6-beat frame -> out_valid stays 1 throughout, data order intact.
REQ-041 Fill 8 frames (DESC_DEPTH) -> in_ready=0 (or 9th frame dropped, drop_count=1 with INGRESS_DROP_EN).
REQ-042 70-beat frame, DEPTH=64, INGRESS_DROP_EN -> frame dropped, drop_count=1, prior committed frames intact, next frame passes.
REQ-043 Reset asserted on beat 3 of 5-beat frame -> out_valid=0, frame_count=0; next frame forwarded correctly.
